// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider bank.
// Holds default widths/divisors, the channel-count ceiling and the
// per-channel state encoding.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF    = 24;
    localparam int unsigned DIV_INIT_DEF = 3;
    localparam int unsigned MAX_CH       = 8;
    localparam int unsigned CH_IDX_W     = 3;

    // HALT: divisor 0; RUN: counting; PEND: shadow divisor waits for wrap.
    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } chan_state_t;

endpackage

// File: rtl/clk_div_if.sv
// Control/status bundle of the divider bank.
// master: sync, cfg_valid, cfg_ch, cfg_div out; cfg_ready, tick, sq, pend in.
// slave : mirror of master.
interface clk_div_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 24
) ();

    logic              sync;
    logic              cfg_valid;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] pend;

    modport master (
        output sync, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, tick, sq, pend
    );

    modport slave (
        input  sync, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, tick, sq, pend
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active and shadow divisor, state, tick, sq.
// Ports: clk, rst (async active-high), sync (phase restart), wr (accepted
// update for this channel), cfg_div (new divisor), tick/sq/pend outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             tick,
    output logic             sq,
    output logic             pend
);

    chan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic             wrap_c;
    logic [CNT_W-1:0] sync_div_c;

    // Last count of the period; div is never 0 outside HALT.
    assign wrap_c = (cnt == div - CNT_W'(1));

    // Divisor that takes effect on a sync edge: a fresh write beats a waiting shadow.
    assign sync_div_c = wr ? cfg_div : ((state == PEND) ? shadow : div);

    assign pend = (state == PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= (DIV_INIT == 0) ? HALT : RUN;
            cnt    <= '0;
            div    <= CNT_W'(DIV_INIT);
            shadow <= '0;
            tick   <= 1'b0;
            sq     <= 1'b0;
        end else if (sync) begin
            // Restart in phase; suppresses any coincident wrap tick.
            state <= (sync_div_c == '0) ? HALT : RUN;
            div   <= sync_div_c;
            cnt   <= '0;
            tick  <= 1'b0;
            sq    <= 1'b0;
        end else begin
            case (state)
                HALT: begin
                    cnt  <= '0;
                    tick <= 1'b0;
                    sq   <= 1'b0;
                    if (wr) begin
                        div   <= cfg_div;
                        state <= (cfg_div == '0) ? HALT : RUN;
                    end
                end
                RUN, PEND: begin
                    if (wrap_c) begin
                        cnt  <= '0;
                        tick <= 1'b1;
                        sq   <= ~sq;
                        if (state == PEND) begin
                            div   <= shadow;
                            state <= (shadow == '0) ? HALT : RUN;
                        end
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        tick <= 1'b0;
                    end
                    // A write while running waits for the next wrap.
                    if (wr && state == RUN) begin
                        shadow <= cfg_div;
                        state  <= PEND;
                    end
                end
                default: begin
                    state <= HALT;
                    cnt   <= '0;
                    tick  <= 1'b0;
                    sq    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers sharing one config port and sync.
// Ports: clk, rst (async active-high), bus (clk_div_if slave: sync, cfg_*,
// cfg_ready, tick, sq, pend).
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    clk_div_if.slave   bus
);

    logic [NUM_CH-1:0] tick_v;
    logic [NUM_CH-1:0] sq_v;
    logic [NUM_CH-1:0] pend_v;
    logic [NUM_CH-1:0] wr_v;
    logic [MAX_CH-1:0] pend_pad;
    logic              ready_c;

    // Unpopulated channel slots read as not pending, so writes there are
    // always accepted and then dropped.
    assign pend_pad = MAX_CH'(pend_v);
    assign ready_c  = ~pend_pad[bus.cfg_ch];

    assign bus.cfg_ready = ready_c;
    assign bus.tick      = tick_v;
    assign bus.sq        = sq_v;
    assign bus.pend      = pend_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Channel decode of an accepted update.
        assign wr_v[i] = bus.cfg_valid & ready_c & (bus.cfg_ch == CH_IDX_W'(i));

        clk_div_chan #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .sync    (bus.sync),
            .wr      (wr_v[i]),
            .cfg_div (bus.cfg_div),
            .tick    (tick_v[i]),
            .sq      (sq_v[i]),
            .pend    (pend_v[i])
        );
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CH, default 3, number of independent divider channels (1..8).
REQ-002 Parameter CNT_W, default 24, divisor and counter width in bits (2..32).
REQ-003 Parameter DIV_INIT, default 3, divisor loaded into every channel at reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 sync  input  1  restart all channels in phase.
REQ-007 cfg_valid  input  1  divisor update request.
REQ-008 cfg_ch  input  3  target channel index.
REQ-009 cfg_div  input  CNT_W  new divisor N; 0 halts the channel.
REQ-010 cfg_ready  output  1  update accepted when cfg_valid & cfg_ready.
REQ-011 tick  output  NUM_CH  per-channel one-cycle pulse, period N cycles.
REQ-012 sq  output  NUM_CH  per-channel square wave, period 2N cycles, 50% duty.
REQ-013 pend  output  NUM_CH  per-channel update-pending flag.

Function
REQ-014 Each channel counter counts 0..N-1; at count N-1 it wraps to 0 on the next edge.
REQ-015 tick[i] is registered, high for exactly the one cycle after the wrap edge; sq[i] toggles on that same edge.
REQ-016 N=1: tick[i] constantly high, sq[i] toggles every cycle.
REQ-017 N=0: counter held at 0, tick[i]=0, sq[i] forced 0.
REQ-018 Channel states: HALT (N=0), RUN (N>0, no pending update), PEND (shadow divisor waiting for wrap).
REQ-019 cfg_ready = ~pend[cfg_ch] for cfg_ch < NUM_CH; cfg_ready=1 for cfg_ch >= NUM_CH, and such requests are discarded.
REQ-020 An accepted update to a RUN channel stores cfg_div in a shadow register and enters PEND; pend[i]=1 from the next cycle.
REQ-021 A PEND channel loads the shadow divisor on its wrap edge (counter to 0, tick/sq behave as a normal wrap) and returns to RUN or HALT; pend[i] clears on that edge.
REQ-022 An accepted update to a HALT channel applies on the next edge: counter=0, sq=0, no tick, no pend.
REQ-023 Accepted update with cfg_div equal to current N still goes through PEND (no short-cut).
REQ-024 sync=1: all counters to 0, all sq to 0, all tick to 0 on the next edge; every pending shadow divisor applies immediately; all pend clear.
REQ-025 sync coincident with a wrap: sync wins, no tick generated.
REQ-026 sync coincident with an accepted update: the new divisor applies immediately, pend stays 0.
REQ-027 Counter and divisor compare are unsigned, CNT_W bits; no overflow possible since count < N <= 2^CNT_W-1.
REQ-028 Channels are fully independent except for sync and the shared cfg port.

Reset
REQ-029 On rst: every counter 0, divisor DIV_INIT, shadow 0, state RUN (HALT if DIV_INIT=0), tick=0, sq=0, pend=0.
REQ-030 rst asserted mid-count or mid-PEND discards all progress and pending updates; first wrap after release occurs DIV_INIT cycles later.
REQ-031 cfg_ready is 1 during reset; requests during reset are ignored.

Structure
REQ-032 Shared package clk_div_pkg holds CNT_W default, DIV_INIT default, MAX_CH=8 and the channel state enum (HALT, RUN, PEND).
REQ-033 One sub-module clk_div_chan implements a single channel (counter, divisor, shadow, state, tick, sq); clk_div_bank instantiates NUM_CH copies and decodes cfg_ch.

Verification
REQ-034 Reset release, defaults -> each tick pulses every 3 cycles, sq period 6 cycles, first tick 3 cycles after release.
REQ-035 Ch1 at N=3, write cfg_div=5 at count 0 -> pend[1]=1, cfg_ready=0 for ch1, two more N=3 cycles, then tick spacing 5, pend clears at wrap.
REQ-036 Write cfg_div=0 to ch0, then cfg_div=1 -> after wrap ch0 halts (tick=0, sq=0); next write gives tick constantly high, sq toggling each cycle.
REQ-037 Channels at N=3,4,7 free-running, assert sync for 1 cycle on a ch0 wrap cycle -> no ch0 tick that cycle; all channels realigned, next ticks at +3, +4, +7 cycles.
REQ-038 Assert rst asynchronously mid-PEND on ch2 -> outputs 0 immediately, pend=0, ch2 resumes at DIV_INIT=3.
REQ-039 cfg_valid with cfg_ch=7, NUM_CH=3 -> cfg_ready=1, no channel changes.
